// File: rtl/scm_bist_march_ctrl.sv
// March C- BIST controller driving the test port of a latch-based SCM register file.
// Define SCM_BIST_CHECKERBOARD_EN to add a second pass with a 0x55/0xAA checkerboard background.
module scm_bist_march_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [3:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_bits_o,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  output logic [NUM_BYTE-1:0]   BE_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [2:0]            ELEM_LAST = 3'd5;
`ifdef SCM_BIST_CHECKERBOARD_EN
  localparam logic                  LAST_PASS = 1'b1;
`else
  localparam logic                  LAST_PASS = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    phase_q;
  logic [2:0]              elem_q;
  logic                    pass_q;

  logic                    start_accept;
  logic                    elem_desc, elem_wr_only, elem_rd_only;
  logic                    is_read, is_write, op_done, last_op, last_elem;
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic [2:0]              elem_nxt;
  logic [DATA_WIDTH-1:0]   bg, exp_rd, wr_data;

  logic                    rd_vld_q;
  logic [DATA_WIDTH-1:0]   exp_data_q;
  logic [ADDR_WIDTH-1:0]   exp_addr_q;
  logic [3:0]              exp_elem_q;
  logic                    mismatch;

  // Element decode: which half of the r/w pair runs this cycle and where the element ends.
  assign start_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  assign elem_desc    = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign elem_wr_only = (elem_q == 3'd0);
  assign elem_rd_only = (elem_q == ELEM_LAST);
  assign is_read      = (state_q == S_RUN) && (elem_rd_only || (!elem_wr_only && !phase_q));
  assign is_write     = (state_q == S_RUN) && (elem_wr_only || (!elem_rd_only && phase_q));
  assign op_done      = elem_wr_only || elem_rd_only || phase_q;
  assign end_addr     = elem_desc ? '0 : ADDR_MAX;
  assign last_op      = (state_q == S_RUN) && op_done && (addr_q == end_addr);
  assign last_elem    = (elem_q == ELEM_LAST);
  assign elem_nxt     = last_elem ? 3'd0 : elem_q + 3'd1;

  assign bg      = pass_q ? {NUM_BYTE{8'h55}} : '0;
  assign exp_rd  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg : bg;
  assign wr_data = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~bg : bg;

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned
  // (that would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_RUN;
      S_RUN:          if (last_op) state_d = (last_elem && (pass_q == LAST_PASS)) ? S_DRAIN : S_GAP;
      S_GAP:          state_d = S_RUN;
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_RUN) || (state_q == S_GAP) || (state_q == S_DRAIN);
    done_o = (state_q == S_DONE);
    BIST   = busy_o;
    CSN_T  = !(is_read || is_write);
    WEN_T  = !is_write;
    A_T    = addr_q;
    D_T    = is_write ? wr_data : '0;
    BE_T   = '1;
  end

  // Address/element sequencer; the next element's start address is loaded on its
  // predecessor's last op so the GAP cycle only has to idle the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      phase_q <= 1'b0;
      elem_q  <= 3'd0;
    end else if (start_accept) begin
      addr_q  <= '0;
      phase_q <= 1'b0;
      elem_q  <= 3'd0;
    end else if (state_q == S_RUN) begin
      if (!op_done) begin
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        if (addr_q == end_addr) begin
          elem_q <= elem_nxt;
          addr_q <= ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADDR_MAX : '0;
        end else begin
          addr_q <= elem_desc ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
        end
      end
    end
  end

`ifdef SCM_BIST_CHECKERBOARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pass_q <= 1'b0;
    else if (start_accept)         pass_q <= 1'b0;
    else if (last_op && last_elem) pass_q <= 1'b1;
  end
`else
  assign pass_q = 1'b0;
`endif

  // Read compare: expectation registered with the read, checked against Q_T one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      exp_data_q <= '0;
      exp_addr_q <= '0;
      exp_elem_q <= '0;
    end else begin
      rd_vld_q <= is_read;
      if (is_read) begin
        exp_data_q <= exp_rd;
        exp_addr_q <= addr_q;
        exp_elem_q <= {pass_q, elem_q};
      end
    end
  end

  assign mismatch = rd_vld_q && (Q_T != exp_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_bits_o <= '0;
    end else if (start_accept) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_bits_o <= '0;
    end else if (mismatch && !fail_o) begin
      fail_o      <= 1'b1;
      fail_addr_o <= exp_addr_q;
      fail_elem_o <= exp_elem_q;
      fail_bits_o <= exp_data_q ^ Q_T;
    end
  end

endmodule

// File: tb/tb_scm_bist_march_ctrl.sv
// Scoreboard bench for scm_bist_march_ctrl with a 32x32 SCM model and injectable faults.
module tb_scm_bist_march_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;
`ifdef SCM_BIST_CHECKERBOARD_EN
  localparam int LAT   = 653;
  localparam int NPASS = 2;
`else
  localparam int LAT   = 327;
  localparam int NPASS = 1;
`endif

  typedef struct {
    logic          csn;
    logic          wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            chk_a;
    bit            chk_d;
  } op_t;

  typedef struct {
    int            cyc;
    logic          fail;
    logic [AW-1:0] addr;
    logic [3:0]    elem;
    logic [DW-1:0] bits;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          busy_o, done_o, fail_o, BIST, CSN_T, WEN_T;
  logic [AW-1:0] fail_addr_o, A_T;
  logic [3:0]    fail_elem_o;
  logic [DW-1:0] fail_bits_o, D_T, Q_T;
  logic [3:0]    BE_T;

  scm_bist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .fail_bits_o(fail_bits_o),
    .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T),
    .BE_T(BE_T), .Q_T(Q_T)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  op_t  op_q[$];
  res_t res_q[$];
  int   fault = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SCM model: 1-cycle read latency, with one of three planted cell faults.
  function automatic logic [DW-1:0] wr_val(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = d;
    if (fault == 3 && a == 5'd4) w[0] = w[1];
    return w;
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a, input logic [DW-1:0] m);
    logic [DW-1:0] r;
    r = m;
    if (fault == 1 && a == 5'd7)  r[3] = 1'b1;
    if (fault == 2 && a == 5'd31) r[0] = 1'b0;
    return r;
  endfunction

  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (!CSN_T) begin
      if (!WEN_T) mem[A_T] <= wr_val(A_T, D_T);
      else        Q_T      <= rd_val(A_T, mem[A_T]);
    end
  end

  // Monitor: per-cycle op check while an op list is queued, result check on done_o rise.
  logic done_prev = 1'b0;
  int   op_idx = 0;
  always @(negedge clk) begin : monitor
    op_t  e;
    res_t r;
    if (busy_o && op_q.size() > 0) begin
      e = op_q.pop_front();
      check($sformatf("op[%0d]", op_idx),
            {CSN_T, WEN_T, (e.chk_a ? A_T : 5'd0), (e.chk_d ? D_T : 32'd0)},
            {e.csn, e.wen, (e.chk_a ? e.a : 5'd0), (e.chk_d ? e.d : 32'd0)});
      op_idx++;
    end
    if (rst_n && done_o && !done_prev) begin
      check("done_expected", 64'(res_q.size() > 0), 64'd1);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(r.cyc));
        check("fail_o", 64'(fail_o), 64'(r.fail));
        check("fail_addr_o", 64'(fail_addr_o), 64'(r.addr));
        check("fail_elem_o", 64'(fail_elem_o), 64'(r.elem));
        check("fail_bits_o", 64'(fail_bits_o), 64'(r.bits));
      end
    end
    done_prev <= done_o;
  end

  task automatic push_op(input logic csn, input logic wen, input int a, input logic [DW-1:0] d,
                         input bit chk_a, input bit chk_d);
    op_t e;
    e.csn = csn; e.wen = wen; e.a = AW'(a); e.d = d; e.chk_a = chk_a; e.chk_d = chk_d;
    op_q.push_back(e);
  endtask

  task automatic push_idle();
    push_op(1'b1, 1'b1, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_rw(input int a, input logic [DW-1:0] wd);
    push_op(1'b0, 1'b1, a, '0, 1'b1, 1'b0);
    push_op(1'b0, 1'b0, a, wd, 1'b1, 1'b1);
  endtask

  // Expected port sequence written straight from the March C- element list.
  task automatic build_ops();
    logic [DW-1:0] bg;
    for (int p = 0; p < NPASS; p++) begin
      bg = (p == 0) ? 32'h0000_0000 : 32'h5555_5555;
      for (int a = 0; a < N; a++) push_op(1'b0, 1'b0, a, bg, 1'b1, 1'b1);
      push_idle();
      for (int a = 0; a < N; a++) push_rw(a, ~bg);
      push_idle();
      for (int a = 0; a < N; a++) push_rw(a, bg);
      push_idle();
      for (int a = N - 1; a >= 0; a--) push_rw(a, ~bg);
      push_idle();
      for (int a = N - 1; a >= 0; a--) push_rw(a, bg);
      push_idle();
      for (int a = 0; a < N; a++) push_op(1'b0, 1'b1, a, '0, 1'b1, 1'b0);
      push_idle();
    end
  endtask

  task automatic start_test(input bit expect_done, input logic f, input logic [AW-1:0] a,
                            input logic [3:0] e, input logic [DW-1:0] b);
    res_t r;
    @(negedge clk);
    start_i = 1'b1;
    if (expect_done) begin
      r.cyc = cyc + LAT; r.fail = f; r.addr = a; r.elem = e; r.bits = b;
      res_q.push_back(r);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done_o && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", 64'(done_o), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_fail"}, 64'(fail_o), 64'd0);
    check({tag, "_bist"}, 64'(BIST), 64'd0);
    check({tag, "_csn"},  64'(CSN_T), 64'd1);
    check({tag, "_wen"},  64'(WEN_T), 64'd1);
    check({tag, "_a"},    64'(A_T), 64'd0);
    check({tag, "_d"},    64'(D_T), 64'd0);
    check({tag, "_be"},   64'(BE_T), 64'hF);
    check({tag, "_faddr"}, 64'(fail_addr_o), 64'd0);
    check({tag, "_felem"}, 64'(fail_elem_o), 64'd0);
    check({tag, "_fbits"}, 64'(fail_bits_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run with the full op sequence checked.
    fault = 0;
    build_ops();
    start_test(1'b1, 1'b0, 5'd0, 4'd0, 32'h0);
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("bist_after_start", 64'(BIST), 64'd1);
    wait_done(LAT + 20);
    check("ops_consumed", 64'(op_q.size()), 64'd0);

    // Address 7 bit 3 stuck-at-1: caught by the first r0.
    fault = 1;
    start_test(1'b1, 1'b1, 5'd7, 4'd1, 32'h0000_0008);
    wait_done(LAT + 20);

    // Address 31 bit 0 stuck-at-0: caught by the r1 of element 2.
    fault = 2;
    start_test(1'b1, 1'b1, 5'd31, 4'd2, 32'h0000_0001);
    wait_done(LAT + 20);

    // Restart from a failed DONE; start pulses while busy must be ignored.
    fault = 0;
    start_test(1'b1, 1'b0, 5'd0, 4'd0, 32'h0);
    check("fail_cleared", 64'(fail_o), 64'd0);
    check("fail_addr_cleared", 64'(fail_addr_o), 64'd0);
    check("done_cleared", 64'(done_o), 64'd0);
    repeat (31) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (60) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(LAT + 20);
    start_test(1'b1, 1'b0, 5'd0, 4'd0, 32'h0);
    check("done_cleared_rerun", 64'(done_o), 64'd0);
    check("busy_rerun", 64'(busy_o), 64'd1);
    wait_done(LAT + 20);

    // Asynchronous reset in element 3, then a clean restart.
    start_test(1'b0, 1'b0, 5'd0, 4'd0, 32'h0);
    repeat (180) @(negedge clk);
    check("in_element3_busy", 64'(busy_o), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    @(negedge clk);
    start_test(1'b1, 1'b0, 5'd0, 4'd0, 32'h0);
    wait_done(LAT + 20);

`ifdef SCM_BIST_CHECKERBOARD_EN
    // Address 4 bit 1 coupled into bit 0: invisible to solid data, caught in pass 1.
    fault = 3;
    start_test(1'b1, 1'b1, 5'd4, 4'h9, 32'h0000_0001);
    wait_done(LAT + 20);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scm_bist_march_ctrl.md
# scm_bist_march_ctrl

March C- built-in self-test controller for the latch-based standard-cell memory (SCM) register files. It drives the BIST test port of the SCM test wrapper: chip select, write enable, address, data and byte enable. It checks read data returned on Q_T and reports pass/fail with the first failing location. It sits beside each SCM instance and is started by the SoC test controller or a debug register.

## Interface
Parameters:
- ADDR_WIDTH, 5, address width of the target SCM; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width of the target SCM
- NUM_BYTE, DATA_WIDTH/8, byte-enable width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled only in IDLE/DONE
- busy_o  out  1  test in progress
- done_o  out  1  test complete; level, held until next accepted start
- fail_o  out  1  sticky mismatch flag; valid when done_o=1
- fail_addr_o  out  ADDR_WIDTH  address of first mismatch
- fail_elem_o  out  4  [3] pass index, [2:0] march element of first mismatch
- fail_bits_o  out  DATA_WIDTH  expected XOR Q_T at first mismatch
- BIST  out  1  mux select into SCM wrapper; equals busy_o
- CSN_T  out  1  active-low chip select
- WEN_T  out  1  active-low write enable (1 = read)
- A_T  out  ADDR_WIDTH  address
- D_T  out  DATA_WIDTH  write data
- BE_T  out  NUM_BYTE  byte enable; constant all-ones
- Q_T  in  DATA_WIDTH  read data from SCM

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE/DONE + start_i=1 -> RUN; clears fail_o, fail_addr_o, fail_elem_o, fail_bits_o and done_o; element=0.
- start_i in RUN/GAP/DRAIN is ignored.
- Elements (D0 = background, D1 = ~D0, solid D0 = all zeros):
  - 0: ascending w0
  - 1: ascending r0,w1
  - 2: ascending r1,w0
  - 3: descending r0,w1
  - 4: descending r1,w0
  - 5: ascending r0
- One op per cycle in RUN.
  - Read: CSN_T=0, WEN_T=1.
  - Write: CSN_T=0, WEN_T=0, D_T=pattern.
  - In r/w elements, read of address a precedes write of a.
- Address counter: ascending runs 0..N-1, descending runs N-1..0; wraps to the start address of the next element.
- End of element 0..4 -> GAP: exactly one idle cycle (CSN_T=1, WEN_T=1). GAP then returns to RUN with element+1.
- End of the final element -> DRAIN for one cycle (last read compare), then DONE.
- Compare: each read registers expected data and address. In the following cycle Q_T is compared against that expected data.
- On the first mismatch, fail_o is set and fail_addr_o/fail_elem_o/fail_bits_o are captured. Later mismatches leave them unchanged. The test always runs to completion.
- Async reset at any time -> IDLE. Reset values of all outputs: busy_o, done_o, fail_o, BIST = 0; CSN_T=1; WEN_T=1; A_T=0; D_T=0; fail_addr_o=0; fail_elem_o=0; fail_bits_o=0; BE_T=all ones.

## Timing
- Read latency: Q_T is valid exactly one cycle after the read op cycle.
- Write-to-read turnaround: a read of an address is issued at least 2 cycles after a write to the same address. The GAP cycle guarantees this at element boundaries, e.g. element 2 writes address N-1, then element 3 reads address N-1.
- Start accepted in cycle T: first op in T+1; busy_o/BIST=1 from T+1.
- Op count 10N, plus 5 GAP cycles, plus 1 DRAIN cycle. done_o rises in cycle T+10N+7 (T+327 for N=32), when busy_o falls.
- fail outputs are stable whenever done_o=1.

## Configuration
- SCM_BIST_CHECKERBOARD_EN defined:
  - After pass 0 (solid background) there is one GAP cycle.
  - Pass 1 then repeats elements 0-5 with D0 = 0x55 replicated per byte and D1 = 0xAA replicated per byte.
  - fail_elem_o[3] = pass index.
  - done_o rises at T+20N+13 (T+653 for N=32).
- Not defined: a single solid pass only; fail_elem_o[3] is tied to 0.

## Test plan
- Ideal 32x32 SCM model with 1-cycle read, start pulse at T -> done_o at T+327, fail_o=0. The op sequence matches the element list, including element 3 starting at A_T=31 after one GAP cycle.
- Bit 3 of address 7 stuck-at-1 -> fail_o=1, fail_addr_o=7, fail_elem_o=1, fail_bits_o=0x00000008.
- Bit 0 of address 31 stuck-at-0 -> first mismatch on the r1 of element 2: fail_addr_o=31, fail_elem_o=2, fail_bits_o=0x00000001.
- rst_n asserted in element 3, then released, then restarted -> outputs hold reset values during reset. A full run then passes with done_o at restart+327.
- start_i pulsed while busy_o=1 -> ignored, done timing unchanged. start_i pulsed in DONE -> fail/done cleared and the test reruns.
- SCM_BIST_CHECKERBOARD_EN defined, model bit 0 of address 4 coupled to bit 1 (write of bit 1 copies into bit 0) -> pass 0 clean, pass 1 fails with fail_elem_o[3]=1, fail_addr_o=4; done_o at T+653.
